read_bpm_test_link: RTL and testbench



---
 rtl/bpm_test_link_pkg.sv | 33 +++
 rtl/read_bpm_test_link_if.sv | 10 +
 rtl/read_bpm_test_link.sv | 184 ++++++++++++++++++
 tb/tb_read_bpm_test_link.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_test_link_pkg.sv
// Shared definitions for the BPM test link: word tags, header field
// positions, status codes and the receiver state encoding.
package bpm_test_link_pkg;

  localparam logic [15:0] TAG_HEADER = 16'hA5BE;
  localparam logic [15:0] TAG_X      = 16'hCAFE;
  localparam logic [15:0] TAG_Y      = 16'hBEEF;

  // Header layout: {tag[31:16], mark[15], cell[14:10], zero[9], global[8:5], index[4:0]}
  localparam int TAG_LSB        = 16;
  localparam int HDR_MARK_BIT   = 15;
  localparam int HDR_CELL_LSB   = 10;
  localparam int HDR_ZERO_BIT   = 9;
  localparam int HDR_GLOBAL_LSB = 5;
  localparam int INDEX_W        = 5;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_FIELD    = 2'd1,
    STATUS_SEQUENCE = 2'd2,
    STATUS_FRAMING  = 2'd3
  } statusCode_t;

  typedef enum logic [2:0] {
    RX_WAIT_START = 3'd0,
    RX_HDR        = 3'd1,
    RX_X          = 3'd2,
    RX_Y          = 3'd3,
    RX_SUM        = 3'd4,
    RX_DISCARD    = 3'd5
  } rxState_t;

endpackage

// File: rtl/read_bpm_test_link_if.sv
// AXI-Stream link carrying the 4-word BPM test packets.
interface read_bpm_test_link_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/read_bpm_test_link.sv
// Receive-side checker for the BPM test link: validates every word of the
// header/X/Y/sum packets, per-frame index sequence and FA counter continuity,
// and reports each frame or error as a one-cycle status strobe plus counters.
module read_bpm_test_link
  import bpm_test_link_pkg::*;
#(
  parameter int BPM_COUNT        = 16,
  parameter int CELL_INDEX       = 12,
  parameter int BPM_GLOBAL_INDEX = 2
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraUserRst_n,
  input  logic                       auroraFAstrobe,
  read_bpm_test_link_if.slave        BPM_TEST_AXI_STREAM_RX,
  output logic                       TESTstatusStrobe,
  output logic [1:0]                 TESTstatusCode,
  output logic [31:0]                frameCount,
  output logic [15:0]                errorCount,
  output logic [15:0]                lastFAcycle,
  output logic [2:0]                 dbgRxState
);

  localparam logic [4:0] CELL_FIELD   = 5'(CELL_INDEX);
  localparam logic [3:0] GLOBAL_FIELD = 4'(BPM_GLOBAL_INDEX);
  localparam logic [4:0] LAST_INDEX   = 5'(BPM_COUNT - 1);

  rxState_t    state, nextState;
  logic        ready;
  logic [4:0]  expIndex;
  logic [15:0] faCapture;
  logic        faValid, armed, doneSinceStrobe;

  logic [31:0] word;
  logic        wordLast, accept;
  logic [4:0]  wordIndex;
  logic [15:0] wordFa;
  logic        hdrFieldOk, xFieldOk, yFieldOk, faOk;
  logic        checked, fieldErr, seqErr, lastErr, wordErr;
  logic        startFrame, goodSum, frameDone, missedFrame;
  statusCode_t wordCode;

  function automatic logic [15:0] satInc(input logic [15:0] value, input logic [1:0] step);
    logic [16:0] sum;
    sum = {1'b0, value} + {15'd0, step};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign word      = BPM_TEST_AXI_STREAM_RX.tdata;
  assign wordLast  = BPM_TEST_AXI_STREAM_RX.tlast;
  assign accept    = BPM_TEST_AXI_STREAM_RX.tvalid && ready;
  assign wordIndex = word[INDEX_W-1:0];
  assign wordFa    = word[TAG_LSB +: 16];
  assign BPM_TEST_AXI_STREAM_RX.tready = ready;
  assign dbgRxState = state;

  assign hdrFieldOk = (word[TAG_LSB +: 16] == TAG_HEADER) && word[HDR_MARK_BIT] &&
                      (word[HDR_CELL_LSB +: 5] == CELL_FIELD) && !word[HDR_ZERO_BIT] &&
                      (word[HDR_GLOBAL_LSB +: 4] == GLOBAL_FIELD);
  assign xFieldOk   = (word[TAG_LSB +: 16] == TAG_X) && (word[TAG_LSB-1:INDEX_W] == '0);
  assign yFieldOk   = (word[TAG_LSB +: 16] == TAG_Y) && (word[TAG_LSB-1:INDEX_W] == '0);
  // First packet of a frame checks continuity against the last good frame;
  // later packets must repeat the FA value captured from the first one.
  assign faOk = (expIndex == '0) ? (!faValid || (wordFa == lastFAcycle + 16'd1))
                                 : (wordFa == faCapture);

  // Next-state and per-word classification
  always_comb begin
    nextState   = state;
    checked     = 1'b0;
    fieldErr    = 1'b0;
    seqErr      = 1'b0;
    lastErr     = 1'b0;
    startFrame  = 1'b0;
    wordErr     = 1'b0;
    wordCode    = STATUS_FIELD;
    goodSum     = 1'b0;
    frameDone   = 1'b0;
    missedFrame = 1'b0;
    case (state)
      RX_WAIT_START: if (accept) begin
        if (hdrFieldOk && (wordIndex == '0) && !wordLast) begin
          nextState  = RX_X;
          startFrame = 1'b1;
        end else if (!wordLast) begin
          nextState = RX_DISCARD;
        end
      end
      RX_HDR: begin
        checked  = accept;
        fieldErr = !hdrFieldOk;
        seqErr   = wordIndex != expIndex;
        lastErr  = wordLast;
        if (accept) nextState = RX_X;
      end
      RX_X: begin
        checked  = accept;
        fieldErr = !xFieldOk;
        seqErr   = wordIndex != expIndex;
        lastErr  = wordLast;
        if (accept) nextState = RX_Y;
      end
      RX_Y: begin
        checked  = accept;
        fieldErr = !yFieldOk;
        seqErr   = wordIndex != expIndex;
        lastErr  = wordLast;
        if (accept) nextState = RX_SUM;
      end
      RX_SUM: begin
        checked  = accept;
        seqErr   = (word[TAG_LSB-1:0] != {11'd0, expIndex}) || !faOk;
        lastErr  = !wordLast;
        if (accept) nextState = RX_HDR;
      end
      RX_DISCARD: if (accept && wordLast) nextState = RX_WAIT_START;
      default: nextState = RX_WAIT_START;
    endcase
    wordErr = checked && (fieldErr || seqErr || lastErr);
    if (wordErr) nextState = wordLast ? RX_WAIT_START : RX_DISCARD;
    wordCode    = lastErr ? STATUS_FRAMING : (seqErr ? STATUS_SEQUENCE : STATUS_FIELD);
    goodSum     = checked && !wordErr && (state == RX_SUM);
    frameDone   = goodSum && (expIndex == LAST_INDEX);
    missedFrame = auroraFAstrobe && armed && !(doneSinceStrobe || frameDone);
  end

  // State register
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) state <= RX_WAIT_START;
    else                  state <= nextState;
  end

  // Packet/frame tracking and FA strobe bookkeeping
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      ready           <= 1'b0;
      expIndex        <= '0;
      faCapture       <= '0;
      faValid         <= 1'b0;
      armed           <= 1'b0;
      doneSinceStrobe <= 1'b0;
      frameCount      <= '0;
      errorCount      <= '0;
      lastFAcycle     <= '0;
    end else begin
      ready <= 1'b1;
      if (startFrame) expIndex <= '0;
      if (wordErr) begin
        expIndex <= '0;
        faValid  <= 1'b0;
      end else if (goodSum) begin
        if (expIndex == '0) faCapture <= wordFa;
        if (frameDone) begin
          expIndex    <= '0;
          frameCount  <= frameCount + 32'd1;
          lastFAcycle <= wordFa;
          faValid     <= 1'b1;
        end else begin
          expIndex <= expIndex + 5'd1;
        end
      end
      if (auroraFAstrobe) begin
        armed           <= 1'b1;
        doneSinceStrobe <= 1'b0;
      end else if (frameDone) begin
        doneSinceStrobe <= 1'b1;
      end
      errorCount <= satInc(errorCount, 2'(wordErr) + 2'(missedFrame));
    end
  end

  // Registered status: word error outranks missed frame outranks frame OK
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      TESTstatusStrobe <= 1'b0;
      TESTstatusCode   <= STATUS_OK;
    end else begin
      TESTstatusStrobe <= wordErr || missedFrame || frameDone;
      if (wordErr)          TESTstatusCode <= wordCode;
      else if (missedFrame) TESTstatusCode <= STATUS_FRAMING;
      else                  TESTstatusCode <= STATUS_OK;
    end
  end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Bench for read_bpm_test_link: directed scenarios plus randomized frames,
// checked every cycle against a packet-level behavioural model.
module tb_read_bpm_test_link;

  localparam int BPM_COUNT        = 16;
  localparam int CELL_INDEX       = 12;
  localparam int BPM_GLOBAL_INDEX = 2;
  localparam logic [4:0] CELL5 = 5'(CELL_INDEX);
  localparam logic [3:0] GLOB4 = 4'(BPM_GLOBAL_INDEX);

  localparam int E_NONE = 0, E_TAG = 1, E_IDX = 2, E_YLAST = 3, E_FA = 4,
                 E_SUMNOLAST = 5, E_XCAFF = 6;
  localparam int HUNT = 0, INPKT = 1, SKIP = 2;

  logic        auroraUserClk   = 1'b0;
  logic        auroraUserRst_n = 1'b1;
  logic        auroraFAstrobe  = 1'b0;
  logic        TESTstatusStrobe;
  logic [1:0]  TESTstatusCode;
  logic [31:0] frameCount;
  logic [15:0] errorCount;
  logic [15:0] lastFAcycle;
  logic [2:0]  dbgRxState;

  read_bpm_test_link_if rx();

  read_bpm_test_link #(
    .BPM_COUNT(BPM_COUNT), .CELL_INDEX(CELL_INDEX), .BPM_GLOBAL_INDEX(BPM_GLOBAL_INDEX)
  ) dut (
    .auroraUserClk(auroraUserClk),
    .auroraUserRst_n(auroraUserRst_n),
    .auroraFAstrobe(auroraFAstrobe),
    .BPM_TEST_AXI_STREAM_RX(rx),
    .TESTstatusStrobe(TESTstatusStrobe),
    .TESTstatusCode(TESTstatusCode),
    .frameCount(frameCount),
    .errorCount(errorCount),
    .lastFAcycle(lastFAcycle),
    .dbgRxState(dbgRxState)
  );

  always #5 auroraUserClk = ~auroraUserClk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;
  int strobeCount = 0;
  logic [1:0] lastCode = 2'd0;

  // ---------------- behavioural model ----------------
  int          mMode = HUNT;
  int          mSlot = 0;
  int          mIdx = 0;
  logic [15:0] mFrameFa = '0;
  logic [15:0] mLastFa = '0;
  bit          mFaKnown = 0;
  logic [31:0] mFrames = '0;
  int          mErrs = 0;
  bit          mArmed = 0;
  bit          mDone = 0;
  bit          expStrobe = 0;
  bit          expReady = 0;
  int          expCode = 0;

  function automatic logic [31:0] idealWord(input int slot, input logic [4:0] idx, input logic [15:0] fa);
    case (slot)
      0:       return {16'hA5BE, 1'b1, CELL5, 1'b0, GLOB4, idx};
      1:       return {16'hCAFE, 11'd0, idx};
      2:       return {16'hBEEF, 11'd0, idx};
      default: return {fa, 11'd0, idx};
    endcase
  endfunction

  always @(posedge auroraUserClk or negedge auroraUserRst_n) begin : model
    int code;
    bit wErr, fDone, miss, badSeq, badField;
    logic [31:0] d;
    logic [15:0] fa;
    if (!auroraUserRst_n) begin
      mMode = HUNT; mSlot = 0; mIdx = 0; mFrameFa = '0; mLastFa = '0; mFaKnown = 0;
      mFrames = '0; mErrs = 0; mArmed = 0; mDone = 0;
      expStrobe = 0; expReady = 0; expCode = 0;
    end else begin
      code = 0; wErr = 0; fDone = 0; miss = 0;
      if (rx.tvalid && expReady) begin
        d = rx.tdata;
        fa = d[31:16];
        if (mMode == HUNT) begin
          if (d == idealWord(0, 5'd0, 16'd0) && !rx.tlast) begin
            mMode = INPKT; mSlot = 1; mIdx = 0;
          end else if (!rx.tlast) begin
            mMode = SKIP;
          end
        end else if (mMode == SKIP) begin
          if (rx.tlast) mMode = HUNT;
        end else begin
          if (mSlot == 3) begin
            badField = 0;
            badSeq = d[15:0] != 16'(mIdx);
            if (mIdx == 0) begin
              if (mFaKnown && fa != mLastFa + 16'd1) badSeq = 1;
            end else if (fa != mFrameFa) begin
              badSeq = 1;
            end
          end else begin
            badSeq   = d[4:0] != 5'(mIdx);
            badField = d != idealWord(mSlot, d[4:0], 16'd0);
          end
          if (rx.tlast != (mSlot == 3)) code = 3;
          else if (badSeq)              code = 2;
          else if (badField)            code = 1;
          if (code != 0) begin
            wErr = 1;
            mErrs = (mErrs < 65535) ? mErrs + 1 : 65535;
            mFaKnown = 0; mIdx = 0;
            mMode = rx.tlast ? HUNT : SKIP;
          end else if (mSlot < 3) begin
            mSlot++;
          end else begin
            if (mIdx == 0) mFrameFa = fa;
            mSlot = 0;
            if (mIdx == BPM_COUNT - 1) begin
              fDone = 1; mFrames = mFrames + 32'd1; mLastFa = fa; mFaKnown = 1; mDone = 1; mIdx = 0;
            end else begin
              mIdx++;
            end
          end
        end
      end
      if (auroraFAstrobe) begin
        if (mArmed && !mDone) begin
          miss = 1;
          mErrs = (mErrs < 65535) ? mErrs + 1 : 65535;
        end
        mArmed = 1; mDone = 0;
      end
      expStrobe = wErr || miss || fDone;
      expCode   = wErr ? code : (miss ? 3 : 0);
      expReady  = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge auroraUserClk) begin
    if (checkEn) begin
      checks++;
      if (TESTstatusStrobe !== expStrobe || (expStrobe && TESTstatusCode !== 2'(expCode))) begin
        errors++;
        $display("FAIL status t=%0t strobe=%0b code=%0d required strobe=%0b code=%0d",
                 $time, TESTstatusStrobe, TESTstatusCode, expStrobe, expCode);
      end
      checks++;
      if (frameCount !== mFrames || errorCount !== 16'(mErrs) || lastFAcycle !== mLastFa ||
          rx.tready !== expReady) begin
        errors++;
        $display("FAIL counters t=%0t frames=%0d errs=%0d lastFA=%0h ready=%0b required frames=%0d errs=%0d lastFA=%0h ready=%0b",
                 $time, frameCount, errorCount, lastFAcycle, rx.tready, mFrames, mErrs, mLastFa, expReady);
      end
      if (TESTstatusStrobe === 1'b1) begin
        strobeCount++;
        lastCode = TESTstatusCode;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int gapMax = 0;
  bit randStrobe = 0;

  task automatic expectLit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    auroraFAstrobe = randStrobe && ($urandom_range(0, 99) < 1);
    @(posedge auroraUserClk);
    #1;
    auroraFAstrobe = 1'b0;
  endtask

  task automatic idle(input int n);
    rx.tvalid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulseFA();
    auroraFAstrobe = 1'b1;
    @(posedge auroraUserClk);
    #1;
    auroraFAstrobe = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic l);
    int g;
    g = int'($urandom_range(0, gapMax));
    for (int k = 0; k < g; k++) begin
      rx.tvalid = 1'b0;
      tick();
    end
    rx.tvalid = 1'b1; rx.tdata = d; rx.tlast = l;
    tick();
    rx.tvalid = 1'b0; rx.tlast = 1'b0;
  endtask

  task automatic sendPacket(input logic [4:0] idx, input logic [15:0] fa, input int err);
    logic [31:0] w [4];
    logic [3:0]  lastMask;
    int slot, bitPos;
    w[0] = {16'hA5BE, 1'b1, CELL5, 1'b0, GLOB4, idx};
    w[1] = {16'hCAFE, 11'd0, idx};
    w[2] = {16'hBEEF, 11'd0, idx};
    w[3] = {fa, 11'd0, idx};
    lastMask = 4'b1000;
    case (err)
      E_TAG: begin
        slot = int'($urandom_range(0, 2)); bitPos = int'($urandom_range(16, 31));
        w[slot][bitPos] = ~w[slot][bitPos];
      end
      E_IDX: begin
        slot = int'($urandom_range(0, 3)); bitPos = int'($urandom_range(0, 4));
        w[slot][bitPos] = ~w[slot][bitPos];
      end
      E_YLAST:     lastMask[2] = 1'b1;
      E_FA:        w[3][16] = ~w[3][16];
      E_SUMNOLAST: lastMask[3] = 1'b0;
      E_XCAFF:     w[1][31:16] = 16'hCAFF;
      default: ;
    endcase
    for (int s = 0; s < 4; s++) sendWord(w[s], lastMask[s]);
  endtask

  task automatic sendFrame(input logic [15:0] fa, input int errPkt, input int errKind);
    for (int p = 0; p < BPM_COUNT; p++) sendPacket(5'(p), fa, (p == errPkt) ? errKind : E_NONE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] faR;
    rx.tvalid = 1'b0; rx.tdata = '0; rx.tlast = 1'b0;
    #1 auroraUserRst_n = 1'b0;
    #1 checkEn = 1;
    expectLit("reset strobe", 32'(TESTstatusStrobe), 0);
    expectLit("reset code", 32'(TESTstatusCode), 0);
    expectLit("reset frames", frameCount, 0);
    expectLit("reset errs", 32'(errorCount), 0);
    expectLit("reset lastFA", 32'(lastFAcycle), 0);
    expectLit("reset tready", 32'(rx.tready), 0);
    expectLit("reset state", 32'(dbgRxState), 0);
    repeat (3) @(posedge auroraUserClk);
    #1 auroraUserRst_n = 1'b1;
    idle(2);
    expectLit("tready after release", 32'(rx.tready), 1);

    // three clean frames
    sendFrame(16'd5, -1, E_NONE);
    sendFrame(16'd6, -1, E_NONE);
    sendFrame(16'd7, -1, E_NONE);
    idle(2);
    expectLit("3 frames count", frameCount, 3);
    expectLit("3 frames lastFA", 32'(lastFAcycle), 7);
    expectLit("3 frames errs", 32'(errorCount), 0);
    expectLit("3 frames strobes", 32'(strobeCount), 3);
    expectLit("3 frames model", mFrames, 3);

    // bad X tag in packet 4, rest discarded, next frame resyncs
    sendFrame(16'd8, 4, E_XCAFF);
    idle(2);
    expectLit("CAFF code", 32'(lastCode), 1);
    expectLit("CAFF errs", 32'(errorCount), 1);
    expectLit("CAFF frames", frameCount, 3);
    sendFrame(16'd100, -1, E_NONE);
    idle(2);
    expectLit("resync code", 32'(lastCode), 0);
    expectLit("resync frames", frameCount, 4);

    // index sequence 0,1,3
    sendPacket(5'd0, 16'd101, E_NONE);
    sendPacket(5'd1, 16'd101, E_NONE);
    sendPacket(5'd3, 16'd101, E_NONE);
    idle(2);
    expectLit("skip index code", 32'(lastCode), 2);
    expectLit("skip index errs", 32'(errorCount), 2);
    sendFrame(16'h000F, -1, E_NONE);
    idle(2);
    expectLit("after skip frames", frameCount, 5);

    // FA jump 0x10 -> 0x12, then 0x13 accepted
    sendFrame(16'h0010, -1, E_NONE);
    sendFrame(16'h0012, -1, E_NONE);
    idle(2);
    expectLit("fa jump code", 32'(lastCode), 2);
    expectLit("fa jump errs", 32'(errorCount), 3);
    expectLit("fa jump frames", frameCount, 6);
    sendFrame(16'h0013, -1, E_NONE);
    idle(2);
    expectLit("fa recover frames", frameCount, 7);
    expectLit("fa recover lastFA", 32'(lastFAcycle), 32'h13);

    // tlast on Y word
    sendPacket(5'd0, 16'h0014, E_YLAST);
    idle(2);
    expectLit("Y tlast code", 32'(lastCode), 3);
    expectLit("Y tlast errs", 32'(errorCount), 4);
    expectLit("Y tlast state", 32'(dbgRxState), 0);
    sendFrame(16'h0015, -1, E_NONE);
    idle(2);
    expectLit("Y tlast recover", frameCount, 8);

    // two FA strobes with no frame between
    pulseFA();
    idle(5);
    pulseFA();
    idle(2);
    expectLit("missed code", 32'(lastCode), 3);
    expectLit("missed errs", 32'(errorCount), 5);

    // reset mid-packet
    sendWord({16'hA5BE, 1'b1, CELL5, 1'b0, GLOB4, 5'd0}, 1'b0);
    sendWord({16'hCAFE, 11'd0, 5'd0}, 1'b0);
    auroraUserRst_n = 1'b0;
    #1;
    expectLit("midreset frames", frameCount, 0);
    expectLit("midreset errs", 32'(errorCount), 0);
    expectLit("midreset lastFA", 32'(lastFAcycle), 0);
    expectLit("midreset tready", 32'(rx.tready), 0);
    expectLit("midreset state", 32'(dbgRxState), 0);
    expectLit("midreset strobe", 32'(TESTstatusStrobe), 0);
    repeat (2) @(posedge auroraUserClk);
    #1 auroraUserRst_n = 1'b1;
    idle(2);
    sendFrame(16'd9, -1, E_NONE);
    idle(2);
    expectLit("post reset frames", frameCount, 1);
    expectLit("post reset code", 32'(lastCode), 0);
    expectLit("post reset lastFA", 32'(lastFAcycle), 9);

    // randomized frames with gaps, FA strobes and injected errors
    gapMax = 2;
    randStrobe = 1;
    faR = 16'd10;
    for (int f = 0; f < 40; f++) begin
      faR = ($urandom_range(0, 9) == 0) ? 16'($urandom) : faR + 16'd1;
      if ($urandom_range(0, 3) == 0)
        sendFrame(faR, int'($urandom_range(0, BPM_COUNT - 1)), int'($urandom_range(1, 6)));
      else
        sendFrame(faR, -1, E_NONE);
    end
    randStrobe = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
